// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for two requesters feeding a registered 2:1 data mux.
// The chosen word is held in y and delivered over a valid/ready handshake.
module rr_mux_arbiter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] i0,
    input  logic             req1,
    input  logic [WIDTH-1:0] i1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             s,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic {StEmpty = 1'b0, StFull = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             s_q, s_d;
    logic             last_q, last_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic free;
    logic capture;
    logic xfer;
    logic winner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            y_q     <= '0;
            s_q     <= 1'b0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            s_q     <= s_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        free    = (state_q == StEmpty) | y_ready;
        capture = free & (req0 | req1);
        xfer    = (state_q == StFull) & y_ready;
        // Contended: favour the requester not served last; otherwise the lone one.
        winner  = (req0 & req1) ? ~last_q : req1;

        state_d = state_q;
        y_d     = y_q;
        s_d     = s_q;
        last_d  = last_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        cnt_d   = cnt_q;

        if (xfer) begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            StEmpty: begin
                if (capture) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (xfer && !capture) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase

        if (capture) begin
            y_d    = winner ? i1 : i0;
            s_d    = winner;
            last_d = winner;
            gnt0_d = ~winner;
            gnt1_d = winner;
        end
    end

    assign y_valid  = (state_q == StFull);
    assign y        = y_q;
    assign s        = s_q;
    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed vector bench for rr_mux_arbiter, instantiated with CNT_W=3
// so that counter wrap is reachable in a short run.
module tb_rr_mux_arbiter;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             req0;
    logic [WIDTH-1:0] i0;
    logic             req1;
    logic [WIDTH-1:0] i1;
    logic             gnt0;
    logic             gnt1;
    logic             s;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             y_ready;
    logic [CNT_W-1:0] xfer_cnt;

    rr_mux_arbiter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .i0      (i0),
        .req1    (req1),
        .i1      (i1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .s       (s),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .xfer_cnt(xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             req0;
        logic [WIDTH-1:0] i0;
        logic             req1;
        logic [WIDTH-1:0] i1;
        logic             rdy;
        logic             g0;
        logic             g1;
        logic             s;
        logic [WIDTH-1:0] y;
        logic             v;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    int n_vec  = 0;
    int n_miss = 0;

    // Outputs packed as {gnt0, gnt1, s, y, y_valid, xfer_cnt}.
    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got g0g1_s_y_v_cnt=%b required %b", name, act, exp);
        end
    endtask

    function automatic logic [10:0] outs();
        return {gnt0, gnt1, s, y, y_valid, xfer_cnt};
    endfunction

    task automatic drive(input logic r0, input logic [3:0] d0, input logic r1,
                         input logic [3:0] d1, input logic rdy);
        req0    = r0;
        i0      = d0;
        req1    = r1;
        i1      = d1;
        y_ready = rdy;
    endtask

    initial begin
        //           req0 i0    req1 i1    rdy  g0 g1 s  y     v  cnt
        vecs[0]  = '{1, 4'hA, 0, 4'h0, 1,   1, 0, 0, 4'hA, 1, 3'd0}; // single req0
        vecs[1]  = '{0, 4'h0, 0, 4'h0, 1,   0, 0, 0, 4'hA, 0, 3'd1}; // delivered, drain
        vecs[2]  = '{0, 4'h0, 0, 4'h0, 1,   0, 0, 0, 4'hA, 0, 3'd1}; // ready while empty
        vecs[3]  = '{1, 4'h3, 1, 4'hC, 1,   0, 1, 1, 4'hC, 1, 3'd1}; // last=0 -> req1 wins
        vecs[4]  = '{1, 4'h3, 1, 4'hC, 1,   1, 0, 0, 4'h3, 1, 3'd2};
        vecs[5]  = '{1, 4'h3, 1, 4'hC, 1,   0, 1, 1, 4'hC, 1, 3'd3};
        vecs[6]  = '{1, 4'h3, 1, 4'hC, 1,   1, 0, 0, 4'h3, 1, 3'd4};
        vecs[7]  = '{1, 4'h5, 0, 4'h0, 1,   1, 0, 0, 4'h5, 1, 3'd5}; // load 5
        vecs[8]  = '{0, 4'h0, 1, 4'h6, 0,   0, 0, 0, 4'h5, 1, 3'd5}; // stall x4
        vecs[9]  = '{0, 4'h0, 1, 4'h6, 0,   0, 0, 0, 4'h5, 1, 3'd5};
        vecs[10] = '{0, 4'h0, 1, 4'h6, 0,   0, 0, 0, 4'h5, 1, 3'd5};
        vecs[11] = '{0, 4'h0, 1, 4'h6, 0,   0, 0, 0, 4'h5, 1, 3'd5};
        vecs[12] = '{0, 4'h0, 1, 4'h6, 1,   0, 1, 1, 4'h6, 1, 3'd6}; // deliver 5 + capture 6
        vecs[13] = '{0, 4'h0, 0, 4'h0, 1,   0, 0, 1, 4'h6, 0, 3'd7}; // idle drain
        vecs[14] = '{0, 4'h0, 0, 4'h0, 1,   0, 0, 1, 4'h6, 0, 3'd7};
        vecs[15] = '{1, 4'h1, 0, 4'h0, 1,   1, 0, 0, 4'h1, 1, 3'd7};
        vecs[16] = '{1, 4'h2, 0, 4'h0, 1,   1, 0, 0, 4'h2, 1, 3'd0}; // 8th transfer wraps
        vecs[17] = '{0, 4'h0, 0, 4'h0, 1,   0, 0, 0, 4'h2, 0, 3'd1}; // 9th -> 1
        vecs[18] = '{0, 4'h0, 0, 4'h0, 0,   0, 0, 0, 4'h2, 0, 3'd1};
        vecs[19] = '{0, 4'h0, 1, 4'h9, 0,   0, 1, 1, 4'h9, 1, 3'd1}; // lone req1 while empty
        vecs[20] = '{1, 4'h7, 0, 4'h0, 1,   1, 0, 0, 4'h7, 1, 3'd2};

        rst = 1'b1;
        drive(0, 4'h0, 0, 4'h0, 0);
        #3;
        check("reset_initial", outs(), 11'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < NVEC; k++) begin
            drive(vecs[k].req0, vecs[k].i0, vecs[k].req1, vecs[k].i1, vecs[k].rdy);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", k), outs(),
                  {vecs[k].g0, vecs[k].g1, vecs[k].s, vecs[k].y, vecs[k].v, vecs[k].cnt});
        end

        // Async reset mid-stream with a word in flight, away from any edge.
        drive(0, 4'h0, 0, 4'h0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("reset_async", outs(), 11'b0);
        @(negedge clk);
        rst = 1'b0;

        // last=1 after reset: first contended arbitration goes to req0.
        drive(1, 4'h3, 1, 4'hC, 1);
        @(posedge clk);
        #1;
        check("post_reset_contend0", outs(), {1'b1, 1'b0, 1'b0, 4'h3, 1'b1, 3'd0});
        @(posedge clk);
        #1;
        check("post_reset_contend1", outs(), {1'b0, 1'b1, 1'b1, 4'hC, 1'b1, 3'd1});
        drive(0, 4'h0, 0, 4'h0, 0);
        @(posedge clk);
        #1;
        check("post_reset_stall", outs(), {1'b0, 1'b0, 1'b1, 4'hC, 1'b1, 3'd1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
